// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a byte-addressable, word-organised data
// memory and the MEM/WB pipeline register.
// Supported accesses: byte, half and word loads and stores, sign or zero
// extended, little-endian.
// Accesses that are not naturally aligned are flagged and suppressed.
// Optional feature: define MEM_STATS_EN to add the LoadCount/StoreCount
// counters of completed aligned accesses.
module mem_stage #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResult_MEM,
  input  logic [31:0] WriteData_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        RegWrite_MEM,
  input  logic [1:0]  MemSize_MEM,
  input  logic        MemSigned_MEM,
  input  logic [4:0]  WriteReg_MEM,
  input  logic        Stall,
  input  logic        Flush,
  output logic [31:0] ReadData_WB,
  output logic [31:0] Address_WB,
  output logic        MemtoReg_WB,
  output logic        RegWrite_WB,
  output logic [4:0]  WriteReg_WB,
  output logic        MisAlign_WB
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] LoadCount,
  output logic [15:0] StoreCount
`endif
);

  localparam int AW = $clog2(DMEM_WORDS);

  // Merge store data into the old word: only the addressed lane(s) change.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (size)
      2'b00:   res[{lane, 3'b000} +: 8] = data[7:0];
      2'b01:   res[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: res = data;
    endcase
    return res;
  endfunction

  // Select the addressed lane(s) and extend to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = {{24{sgn & b[7]}}, b};
      2'b01:   res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Natural alignment test; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lane);
    logic res;
    case (size)
      2'b00:   res = 1'b0;
      2'b01:   res = lane[0];
      default: res = (lane != 2'b00);
    endcase
    return res;
  endfunction

  logic [31:0]   mem_r [DMEM_WORDS];
  logic [AW-1:0] word_idx_s;
  logic [1:0]    lane_s;
  logic          misalign_s;
  logic          advance_s;
  logic          store_en_s;
  logic          load_ok_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   load_data_s;
  logic [31:0]   store_word_s;

  // Address decode, alignment check and load/store datapath.
  always_comb begin
    word_idx_s   = ALUResult_MEM[AW+1:2];
    lane_s       = ALUResult_MEM[1:0];
    rd_word_s    = mem_r[word_idx_s];
    advance_s    = ~Stall & ~Flush;
    if (MemRead_MEM | MemWrite_MEM) begin
      misalign_s = is_misaligned(MemSize_MEM, lane_s);
    end else begin
      misalign_s = 1'b0;
    end
    store_en_s   = MemWrite_MEM & advance_s & ~misalign_s;
    load_ok_s    = MemRead_MEM & ~misalign_s;
    load_data_s  = extract_load(rd_word_s, MemSize_MEM, lane_s, MemSigned_MEM);
    store_word_s = merge_store(rd_word_s, WriteData_MEM, MemSize_MEM, lane_s);
  end

  // Data memory: cleared by reset, written on enabled aligned stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem_r[i[AW-1:0]] <= 32'h0000_0000;
      end
    end else if (store_en_s) begin
      mem_r[word_idx_s] <= store_word_s;
    end
  end

  // MEM/WB pipeline register; flush wins over stall, reset wins over both.
  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      ReadData_WB <= 32'h0000_0000;
      Address_WB  <= 32'h0000_0000;
      MemtoReg_WB <= 1'b0;
      RegWrite_WB <= 1'b0;
      WriteReg_WB <= 5'd0;
      MisAlign_WB <= 1'b0;
    end else if (Stall) begin
      ReadData_WB <= ReadData_WB;
      Address_WB  <= Address_WB;
      MemtoReg_WB <= MemtoReg_WB;
      RegWrite_WB <= RegWrite_WB;
      WriteReg_WB <= WriteReg_WB;
      MisAlign_WB <= MisAlign_WB;
    end else begin
      ReadData_WB <= load_ok_s ? load_data_s : 32'h0000_0000;
      Address_WB  <= ALUResult_MEM;
      MemtoReg_WB <= MemtoReg_MEM;
      RegWrite_WB <= RegWrite_MEM & ~(MemRead_MEM & misalign_s);
      WriteReg_WB <= WriteReg_MEM;
      MisAlign_WB <= misalign_s;
    end
  end

`ifdef MEM_STATS_EN
  logic [15:0] load_cnt_r;
  logic [15:0] store_cnt_r;

  // Count completed aligned accesses; the counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_r  <= 16'h0000;
      store_cnt_r <= 16'h0000;
    end else begin
      if (advance_s && load_ok_s) begin
        load_cnt_r <= load_cnt_r + 16'h0001;
      end
      if (store_en_s) begin
        store_cnt_r <= store_cnt_r + 16'h0001;
      end
    end
  end

  assign LoadCount  = load_cnt_r;
  assign StoreCount = store_cnt_r;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage (default DMEM_WORDS=64).
// Counter checks are included when MEM_STATS_EN is defined.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] ALUResult_MEM;
  logic [31:0] WriteData_MEM;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic        MemtoReg_MEM;
  logic        RegWrite_MEM;
  logic [1:0]  MemSize_MEM;
  logic        MemSigned_MEM;
  logic [4:0]  WriteReg_MEM;
  logic        Stall;
  logic        Flush;
  logic [31:0] ReadData_WB;
  logic [31:0] Address_WB;
  logic        MemtoReg_WB;
  logic        RegWrite_WB;
  logic [4:0]  WriteReg_WB;
  logic        MisAlign_WB;
`ifdef MEM_STATS_EN
  logic [15:0] LoadCount;
  logic [15:0] StoreCount;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        chk_rd;
    logic [31:0] addr;
    logic        m2r;
    logic        rw;
    logic [4:0]  wr;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];

  mem_stage #(.DMEM_WORDS(64)) dut (
    .clk(clk), .rst(rst),
    .ALUResult_MEM(ALUResult_MEM), .WriteData_MEM(WriteData_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .MemtoReg_MEM(MemtoReg_MEM), .RegWrite_MEM(RegWrite_MEM),
    .MemSize_MEM(MemSize_MEM), .MemSigned_MEM(MemSigned_MEM),
    .WriteReg_MEM(WriteReg_MEM), .Stall(Stall), .Flush(Flush),
    .ReadData_WB(ReadData_WB), .Address_WB(Address_WB),
    .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB),
    .WriteReg_WB(WriteReg_WB), .MisAlign_WB(MisAlign_WB)
`ifdef MEM_STATS_EN
    , .LoadCount(LoadCount), .StoreCount(StoreCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] rd, input logic chk_rd,
                              input logic [31:0] addr, input logic m2r, input logic rw,
                              input logic [4:0] wr, input logic mis);
    exp_t e;
    e.tag = tag; e.rd = rd; e.chk_rd = chk_rd; e.addr = addr;
    e.m2r = m2r; e.rw = rw; e.wr = wr; e.mis = mis;
    return e;
  endfunction

  // Drive one MEM cycle, queue its expectation, clock, then compare WB.
  task automatic step(input logic r, input logic mr, input logic mw, input logic st,
                      input logic fl, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic sg, input logic m2r,
                      input logic rw, input logic [4:0] wr, input exp_t e);
    exp_t got;
    rst = r; MemRead_MEM = mr; MemWrite_MEM = mw; Stall = st; Flush = fl;
    ALUResult_MEM = a; WriteData_MEM = wd; MemSize_MEM = sz; MemSigned_MEM = sg;
    MemtoReg_MEM = m2r; RegWrite_MEM = rw; WriteReg_MEM = wr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      got = sb_q.pop_front();
      if (got.chk_rd) check({got.tag, ".rd"}, ReadData_WB, got.rd);
      check({got.tag, ".addr"}, Address_WB, got.addr);
      check({got.tag, ".m2r"}, {31'd0, MemtoReg_WB}, {31'd0, got.m2r});
      check({got.tag, ".rw"}, {31'd0, RegWrite_WB}, {31'd0, got.rw});
      check({got.tag, ".wr"}, {27'd0, WriteReg_WB}, {27'd0, got.wr});
      check({got.tag, ".mis"}, {31'd0, MisAlign_WB}, {31'd0, got.mis});
    end
  endtask

  // Aligned load with MemtoReg=1, RegWrite=1.
  task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] sz,
                    input logic sg, input logic [4:0] wr, input logic [31:0] exp_rd);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 32'h0, sz, sg, 1'b1, 1'b1, wr,
         mk(tag, exp_rd, 1'b1, a, 1'b1, 1'b1, wr, 1'b0));
  endtask

  // Aligned store, no register write-back.
  task automatic sto(input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, wd, sz, 1'b0, 1'b0, 1'b0, 5'd0,
         mk(tag, 32'h0, 1'b1, a, 1'b0, 1'b0, 5'd0, 1'b0));
  endtask

  initial begin
    // Reset with junk on the inputs: everything clears.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h123, 32'hFFFF_FFFF, 2'b10, 1'b1, 1'b1, 1'b1, 5'd31,
         mk("reset", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0));

    // Word store / load round trip.
    sto("sw10", 32'h10, 32'hDEAD_BEEF, 2'b10);
    ld("lw10", 32'h10, 2'b10, 1'b0, 5'd5, 32'hDEAD_BEEF);

    // Byte store only updates lane 1; sign/zero extension.
    sto("sb21", 32'h21, 32'h1234_5680, 2'b00);
    ld("lb21", 32'h21, 2'b00, 1'b1, 5'd7, 32'hFFFF_FF80);
    ld("lbu21", 32'h21, 2'b00, 1'b0, 5'd8, 32'h0000_0080);
    ld("lw20", 32'h20, 2'b10, 1'b0, 5'd9, 32'h0000_8000);

    // Half accesses on word 0.
    sto("sw00", 32'h00, 32'h8001_7F02, 2'b10);
    ld("lh02", 32'h02, 2'b01, 1'b1, 5'd1, 32'hFFFF_8001);
    ld("lhu02", 32'h02, 2'b01, 1'b0, 5'd2, 32'h0000_8001);
    ld("lh00", 32'h00, 2'b01, 1'b1, 5'd3, 32'h0000_7F02);
    sto("sh02", 32'h02, 32'h1234_A5C3, 2'b01);
    ld("lw00", 32'h00, 2'b10, 1'b0, 5'd4, 32'hA5C3_7F02);

    // Misaligned half load: flagged, no register write.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h03, 32'h0, 2'b01, 1'b1, 1'b1, 1'b1, 5'd3,
         mk("lh03", 32'h0, 1'b0, 32'h03, 1'b1, 1'b0, 5'd3, 1'b1));

    // Misaligned word store leaves memory untouched.
    sto("sw04", 32'h04, 32'h1111_1111, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h06, 32'h2222_2222, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0,
         mk("sw06", 32'h0, 1'b1, 32'h06, 1'b0, 1'b0, 5'd0, 1'b1));
    ld("lw04a", 32'h04, 2'b10, 1'b0, 5'd9, 32'h1111_1111);

    // Stalled store: outputs hold, memory unchanged.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h04, 32'h3333_3333, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0,
         mk("stall", 32'h1111_1111, 1'b1, 32'h04, 1'b1, 1'b1, 5'd9, 1'b0));
    ld("lw04b", 32'h04, 2'b10, 1'b0, 5'd10, 32'h1111_1111);

    // Stall+Flush: all zero, store blocked.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 32'h4444_4444, 2'b10, 1'b0, 1'b1, 1'b1, 5'd11,
         mk("flush", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0));
    ld("lw04c", 32'h04, 2'b10, 1'b0, 5'd12, 32'h1111_1111);

    // Size 11 behaves as word.
    sto("sw0c", 32'h0C, 32'hCAFE_F00D, 2'b11);
    ld("lw0c", 32'h0C, 2'b11, 1'b1, 5'd13, 32'hCAFE_F00D);

    // Address wrap-around.
    ld("lw100", 32'h100, 2'b10, 1'b0, 5'd14, 32'hA5C3_7F02);
    sto("sw110", 32'h110, 32'h55AA_55AA, 2'b10);
    ld("lw10b", 32'h10, 2'b10, 1'b0, 5'd15, 32'h55AA_55AA);

    // Reset during a store: aborted, memory cleared.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h6666_6666, 2'b10, 1'b0, 1'b1, 1'b1, 5'd16,
         mk("rststore", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0));

    // 2 stores (1 stalled) and 3 loads after reset.
    sto("sw44", 32'h44, 32'h7777_7777, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h48, 32'h8888_8888, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0,
         mk("stall48", 32'h0, 1'b1, 32'h44, 1'b0, 1'b0, 5'd0, 1'b0));
    ld("lw40", 32'h40, 2'b10, 1'b0, 5'd17, 32'h0);
    ld("lw44", 32'h44, 2'b10, 1'b0, 5'd18, 32'h7777_7777);
    ld("lw48", 32'h48, 2'b10, 1'b0, 5'd19, 32'h0);

`ifdef MEM_STATS_EN
    check("LoadCount", {16'd0, LoadCount}, 32'd3);
    check("StoreCount", {16'd0, StoreCount}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
